// File: rtl/params_loader_pkg.sv
// Shared types and fixed-point helpers for the parameter loader and parameters memory.
// PARAMS_LOADER_READBACK_EN (in params_loader) relies on quantize() defined here.
package params_loader_pkg;

    localparam int CIM_PARAMS_BANK_SIZE_NUM_WORD = 15872;
    localparam int TOTAL_WORDS = 2 * CIM_PARAMS_BANK_SIZE_NUM_WORD;
    localparam int ADDR_W = $clog2(TOTAL_WORDS);
    localparam int LEN_W = $clog2(TOTAL_WORDS + 1);
    localparam int CFX_W = 22;
    localparam int PRM_W = 16;
    localparam int EXT_W = CFX_W + 5;
    localparam int PRM_MAX = 2 ** (PRM_W - 1) - 1;
    localparam int PRM_MIN = -(2 ** (PRM_W - 1));

    typedef logic [ADDR_W-1:0] ParamAddr_t;
    typedef logic [LEN_W-1:0] ParamLen_t;
    typedef logic signed [CFX_W-1:0] CompFx_t;
    typedef logic signed [PRM_W-1:0] Param_t;

    // FX_n_X: n integer bits (incl. sign) in a 16-bit word; CompFx_t has 10 fraction bits
    typedef enum logic [2:0] {
        PARAMS_FX_2_X,
        PARAMS_FX_3_X,
        PARAMS_FX_4_X,
        PARAMS_FX_5_X,
        PARAMS_FX_6_X
    } FxFormatParams_t;

    typedef enum logic [2:0] {
        PL_IDLE,
        PL_LOAD,
        PL_RB_ISSUE,
        PL_RB_DRAIN,
        PL_RB_CHECK,
        PL_FINISH
    } ParamLoaderState_t;

    function automatic logic [2:0] param_shift(FxFormatParams_t fmt);
        unique case (fmt)
            PARAMS_FX_2_X: return 3'd4;
            PARAMS_FX_3_X: return 3'd3;
            PARAMS_FX_4_X: return 3'd2;
            PARAMS_FX_5_X: return 3'd1;
            default:       return 3'd0;
        endcase
    endfunction

    function automatic Param_t cast_to_Param_t(CompFx_t x, FxFormatParams_t fmt);
        logic signed [EXT_W-1:0] w;
        w = EXT_W'(x) <<< param_shift(fmt);
        if (w > EXT_W'(PRM_MAX)) return Param_t'(PRM_MAX);
        if (w < EXT_W'(PRM_MIN)) return Param_t'(PRM_MIN);
        return Param_t'(w[PRM_W-1:0]);
    endfunction

    function automatic CompFx_t cast_to_CompFx_t(Param_t p, FxFormatParams_t fmt);
        CompFx_t e;
        e = CompFx_t'(p);
        return e >>> param_shift(fmt);
    endfunction

    function automatic CompFx_t quantize(CompFx_t x, FxFormatParams_t fmt);
        return cast_to_CompFx_t(cast_to_Param_t(x, fmt), fmt);
    endfunction

endpackage

// File: rtl/params_loader_if.sv
// Parameters memory write and read channels.
// The loader holds the master side of both; the memory holds the slave side.
interface params_wr_if;
    import params_loader_pkg::*;

    logic            en;
    logic            chip_en;
    ParamAddr_t      addr;
    CompFx_t         data;
    FxFormatParams_t format;

    modport master (output en, chip_en, addr, data, format);
    modport slave  (input  en, chip_en, addr, data, format);
endinterface

interface params_rd_if;
    import params_loader_pkg::*;

    logic            en;
    ParamAddr_t      addr;
    FxFormatParams_t format;
    CompFx_t         data;

    modport master (output en, addr, format, input  data);
    modport slave  (input  en, addr, format, output data);
endinterface

// File: rtl/params_loader.sv
// Streams a block of CompFx_t words into parameters memory at consecutive addresses.
// Define PARAMS_LOADER_READBACK_EN to re-read the block and flag XOR-checksum mismatches on err.
module params_loader
    import params_loader_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  ParamAddr_t      base_addr,
    input  ParamLen_t       len,
    input  FxFormatParams_t format,
    input  logic            in_valid,
    input  CompFx_t         in_data,
    output logic            in_ready,
    params_wr_if.master     write,
    params_rd_if.master     read,
    output logic            busy,
    output logic            done,
    output logic            err
);

    ParamLoaderState_t state_q, state_d;
    ParamAddr_t        addr_q, addr_d;
    ParamLen_t         cnt_q, cnt_d;
    FxFormatParams_t   fmt_q, fmt_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wen_q, wen_d;
    ParamAddr_t        waddr_q, waddr_d;
    CompFx_t           wdata_q, wdata_d;
    FxFormatParams_t   wfmt_q, wfmt_d;

    logic              xfer;
    logic [LEN_W:0]    end_addr;
    logic              range_err;

`ifdef PARAMS_LOADER_READBACK_EN
    logic              ren_q, ren_d;
    logic              ren_prev_q, ren_prev_d;
    ParamAddr_t        raddr_q, raddr_d;
    ParamAddr_t        rptr_q, rptr_d;
    ParamLen_t         rcnt_q, rcnt_d;
    CompFx_t           exp_q, exp_d;
    CompFx_t           act_q, act_d;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        fmt_d      = fmt_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wfmt_d     = wfmt_q;
        xfer       = in_valid & in_ready_q;
        // one bit wider than len so base+len cannot wrap
        end_addr   = (LEN_W+1)'(base_addr) + (LEN_W+1)'(len);
        range_err  = end_addr > (LEN_W+1)'(TOTAL_WORDS);
`ifdef PARAMS_LOADER_READBACK_EN
        ren_d      = 1'b0;
        ren_prev_d = ren_q;
        raddr_d    = raddr_q;
        rptr_d     = rptr_q;
        rcnt_d     = rcnt_q;
        exp_d      = exp_q;
        act_d      = ren_prev_q ? (act_q ^ read.data) : act_q;
`endif
        unique case (state_q)
            PL_IDLE: begin
                if (start) begin
                    err_d = range_err;
                    if (range_err || len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = PL_LOAD;
                        addr_d     = base_addr;
                        cnt_d      = len;
                        fmt_d      = format;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b1;
`ifdef PARAMS_LOADER_READBACK_EN
                        rptr_d     = base_addr;
                        rcnt_d     = len;
                        exp_d      = '0;
                        act_d      = '0;
`endif
                    end
                end
            end
            PL_LOAD: begin
                if (xfer) begin
                    wen_d   = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = in_data;
                    wfmt_d  = fmt_q;
                    addr_d  = addr_q + ParamAddr_t'(1);
                    cnt_d   = cnt_q - ParamLen_t'(1);
                    if (cnt_q == ParamLen_t'(1)) in_ready_d = 1'b0;
`ifdef PARAMS_LOADER_READBACK_EN
                    exp_d   = exp_q ^ quantize(in_data, fmt_q);
`endif
                end else if (cnt_q == '0) begin
`ifdef PARAMS_LOADER_READBACK_EN
                    state_d = PL_RB_ISSUE;
`else
                    state_d = PL_FINISH;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef PARAMS_LOADER_READBACK_EN
            PL_RB_ISSUE: begin
                ren_d   = 1'b1;
                raddr_d = rptr_q;
                rptr_d  = rptr_q + ParamAddr_t'(1);
                rcnt_d  = rcnt_q - ParamLen_t'(1);
                if (rcnt_q == ParamLen_t'(1)) state_d = PL_RB_DRAIN;
            end
            PL_RB_DRAIN: begin
                state_d = PL_RB_CHECK;
            end
            PL_RB_CHECK: begin
                // act_d already folds in the final returning word
                err_d   = err_q | (act_d != exp_q);
                state_d = PL_FINISH;
                done_d  = 1'b1;
            end
`endif
            PL_FINISH: begin
                busy_d  = 1'b0;
                state_d = PL_IDLE;
            end
            default: begin
                state_d = PL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PL_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            fmt_q      <= PARAMS_FX_2_X;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wfmt_q     <= PARAMS_FX_2_X;
`ifdef PARAMS_LOADER_READBACK_EN
            ren_q      <= 1'b0;
            ren_prev_q <= 1'b0;
            raddr_q    <= '0;
            rptr_q     <= '0;
            rcnt_q     <= '0;
            exp_q      <= '0;
            act_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            fmt_q      <= fmt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wfmt_q     <= wfmt_d;
`ifdef PARAMS_LOADER_READBACK_EN
            ren_q      <= ren_d;
            ren_prev_q <= ren_prev_d;
            raddr_q    <= raddr_d;
            rptr_q     <= rptr_d;
            rcnt_q     <= rcnt_d;
            exp_q      <= exp_d;
            act_q      <= act_d;
`endif
        end
    end

    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign write.en      = wen_q;
    assign write.chip_en = 1'b1;
    assign write.addr    = waddr_q;
    assign write.data    = wdata_q;
    assign write.format  = wfmt_q;

`ifdef PARAMS_LOADER_READBACK_EN
    assign read.en     = ren_q;
    assign read.addr   = raddr_q;
    assign read.format = fmt_q;
`else
    logic unused_rd_data;
    assign read.en        = 1'b0;
    assign read.addr      = '0;
    assign read.format    = PARAMS_FX_2_X;
    assign unused_rd_data = ^read.data;
`endif

endmodule

// File: tb/tb_params_loader.sv
// Randomized self-checking bench for params_loader with a cycle-level reference model.
// Readback scenarios run only when PARAMS_LOADER_READBACK_EN is defined.
module tb_params_loader;
    import params_loader_pkg::*;

`ifdef PARAMS_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    ParamAddr_t      base_addr;
    ParamLen_t       len;
    FxFormatParams_t fmt_in;
    logic            in_valid;
    CompFx_t         in_data;
    logic            in_ready;
    logic            busy;
    logic            done;
    logic            err;

    params_wr_if wr ();
    params_rd_if rd ();

    params_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .format    (fmt_in),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .write     (wr),
        .read      (rd),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int        n_vec = 0;
    int        n_err = 0;
    int        mem [TOTAL_WORDS];
    int        hist_a[$];
    CompFx_t   hist_d[$];
    bit [4:0]  pat = 5'b11001;

    // Stored value as seen back through the memory: saturate to the format's range
    function automatic int qref(CompFx_t x, FxFormatParams_t f);
        int s, hi, lo, v;
        s  = 4 - int'(f);
        hi = (1 << (15 - s)) - 1;
        lo = -(1 << (15 - s));
        v  = int'(x);
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    function automatic CompFx_t rnd_data();
        int r;
        r = int'($urandom_range(0, 32767)) - 16384;
        return CompFx_t'(r);
    endfunction

    always @(posedge clk) begin
        if (wr.en === 1'b1 && int'(wr.addr) < TOTAL_WORDS)
            mem[wr.addr] = qref(wr.data, wr.format);
        if (rd.en === 1'b1 && int'(rd.addr) < TOTAL_WORDS)
            rd.data <= CompFx_t'(mem[rd.addr]);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_block(input int base, input int ln, input int fi,
                             input int mode, input int rst_at,
                             input bit glitch, input bit corrupt);
        FxFormatParams_t f;
        int      bad, acc, xfers, last_k, done_k;
        bit      xfer_now, v, rd_exp, err_exp;
        CompFx_t d;
        int      qa[$];
        CompFx_t qd[$];
        f   = FxFormatParams_t'(fi);
        bad = (base + ln > TOTAL_WORDS) ? 1 : 0;
        acc = (bad == 0 && ln != 0) ? 1 : 0;
        hist_a.delete();
        hist_d.delete();
        @(negedge clk);
        start     = 1'b1;
        base_addr = ParamAddr_t'(base);
        len       = ParamLen_t'(ln);
        fmt_in    = f;
        in_valid  = 1'b0;
        xfers     = 0;
        xfer_now  = 1'b0;
        last_k    = -1;
        done_k    = acc ? -1 : 1;
        for (int k = 1; k < 400; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (rst) begin
                chk("rst_wen", wr.en, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_ready", in_ready, 1'b0);
                chk("rst_done", done, 1'b0);
                rst      = 1'b0;
                in_valid = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_nodone", done, 1'b0);
                    chk("rst_nowen", wr.en, 1'b0);
                end
                return;
            end
            chk("in_ready", in_ready, (acc != 0 && xfers < ln));
            chk("wen", wr.en, xfer_now);
            if (xfer_now) begin
                chk("waddr", wr.addr, qa.pop_front());
                chk("wdata", wr.data, qd.pop_front());
                chk("wfmt", wr.format, f);
                if (xfers == ln) begin
                    last_k = k;
                    done_k = k + 1 + (RB ? ln + 2 : 0);
                end
            end
            rd_exp = RB && last_k > 0 && k >= last_k + 2 && k <= last_k + ln + 1;
            chk("ren", rd.en, rd_exp);
            if (rd_exp) chk("raddr", rd.addr, base + k - last_k - 2);
            chk("done", done, done_k == k);
            chk("busy", busy, acc != 0 && (done_k < 0 || k <= done_k));
            err_exp = (bad != 0) || (corrupt && done_k > 0 && k >= done_k);
            chk("err", err, err_exp);
            if (corrupt && k == last_k + 1) mem[base] = mem[base] ^ 1;
            if (done_k > 0 && k == done_k + 1) break;
            case (mode)
                0:       v = 1'b1;
                1:       v = (k - 1 < 5) ? pat[k-1] : 1'b1;
                default: v = ($urandom_range(0, 9) < 7);
            endcase
            d = rnd_data();
            if (rst_at > 0 && xfers == rst_at) rst = 1'b1;
            in_valid = v;
            in_data  = d;
            xfer_now = v && acc != 0 && xfers < ln && !rst;
            if (xfer_now) begin
                qa.push_back(base + xfers);
                qd.push_back(d);
                hist_a.push_back(base + xfers);
                hist_d.push_back(d);
                xfers++;
            end
            if (glitch && k == 2) begin
                start     = 1'b1;
                base_addr = '0;
                len       = ParamLen_t'(1);
                fmt_in    = PARAMS_FX_6_X;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        fmt_in    = PARAMS_FX_2_X;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", in_ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_wen", wr.en, 1'b0);
        chk("reset_ren", rd.en, 1'b0);
        chk("reset_chip_en", wr.chip_en, 1'b1);
        chk("reset_waddr", wr.addr, 0);
        chk("reset_wdata", wr.data, 0);
        rst = 1'b0;

        run_block(0, 4, 2, 0, 0, 1'b0, 1'b0);
        run_block(15870, 4, 1, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < hist_a.size(); i++)
            chk("bank_mem", mem[hist_a[i]], qref(hist_d[i], PARAMS_FX_3_X));
        run_block(TOTAL_WORDS - 2, 3, 0, 0, 0, 1'b0, 1'b0);
        run_block(10, 0, 0, 0, 0, 1'b0, 1'b0);
        run_block(100, 3, 3, 1, 0, 1'b1, 1'b0);
        run_block(200, 5, 4, 0, 1, 1'b0, 1'b0);
        run_block(300, 5, 4, 0, 0, 1'b0, 1'b0);
        run_block(TOTAL_WORDS - 6, 6, 2, 2, 0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            int l, b, fi;
            l  = $urandom_range(1, 12);
            fi = $urandom_range(0, 4);
            if ($urandom_range(0, 4) == 0)
                b = $urandom_range(TOTAL_WORDS - l + 1, TOTAL_WORDS - 1);
            else
                b = $urandom_range(0, TOTAL_WORDS - l);
            run_block(b, l, fi, 2, 0, 1'b0, 1'b0);
        end
`ifdef PARAMS_LOADER_READBACK_EN
        run_block(500, 8, 3, 0, 0, 1'b0, 1'b0);
        run_block(600, 8, 0, 0, 0, 1'b0, 1'b1);
        run_block(700, 5, 1, 2, 0, 1'b0, 1'b0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
